// File: rtl/ad7476a_adc_emu.sv
// Responder-side emulation of the AD7476A serial ADC: streams {LEAD_ZEROS zeros, sample} on miso.
// Define AD7476A_EMU_RAMP_EN to replace the external holding register with an internal ramp.
module ad7476a_adc_emu #(
   parameter int DATA_W      = 12,
   parameter int LEAD_ZEROS  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ss,
   input  logic              sck,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              sample_valid,
   output logic              sample_ack,
   output logic              conv_done,
   output logic              conv_abort,
   output logic [15:0]       frame_cnt
);

   localparam int FRAME_W = LEAD_ZEROS + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state, state_nxt;
   logic [SYNC_STAGES-1:0] ss_sync, sck_sync;
   logic                 ss_prev, sck_prev;
   logic                 ss_fall, ss_rise, sck_fall;
   logic [DATA_W-1:0]    hold;
   logic [FRAME_W-1:0]   shift, shift_nxt;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
   logic                 miso_nxt, miso_oe_nxt;
   logic                 sample_ack_nxt, conv_done_nxt, conv_abort_nxt;
   logic [15:0]          frame_cnt_nxt;
   logic                 frame_start;

   // Synchronizers idle high so reset release never looks like a select or clock edge.
   // NOTE: every register, including the holding and shift registers, gets a reset value so
   // a mid-frame reset leaves no stale data behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_sync  <= '1;
         sck_sync <= '1;
         ss_prev  <= 1'b1;
         sck_prev <= 1'b1;
         ss_fall  <= 1'b0;
         ss_rise  <= 1'b0;
         sck_fall <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge value,
         // which is what makes this a shift chain rather than a wire.
         ss_sync  <= {ss_sync[SYNC_STAGES-2:0], ss};
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
         ss_prev  <= ss_sync[SYNC_STAGES-1];
         sck_prev <= sck_sync[SYNC_STAGES-1];
         ss_fall  <= ss_prev & ~ss_sync[SYNC_STAGES-1];
         ss_rise  <= ~ss_prev & ss_sync[SYNC_STAGES-1];
         sck_fall <= sck_prev & ~sck_sync[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ss events take priority over sck events, so a late sck fall never counts past an abort.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ss_fall) state_nxt = SHIFT;
         SHIFT: begin
            if (ss_rise)
               state_nxt = IDLE;
            else if (sck_fall && bit_cnt == CNT_W'(FRAME_W - 1))
               state_nxt = DONE;
         end
         DONE:    if (ss_rise) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      // NOTE: defaulting every output of this block first is what keeps it free of latches.
      miso_nxt       = miso;
      miso_oe_nxt    = miso_oe;
      shift_nxt      = shift;
      bit_cnt_nxt    = bit_cnt;
      sample_ack_nxt = 1'b0;
      conv_done_nxt  = 1'b0;
      conv_abort_nxt = 1'b0;
      frame_cnt_nxt  = frame_cnt;
      frame_start    = 1'b0;
      case (state)
         IDLE: begin
            miso_nxt    = 1'b0;
            miso_oe_nxt = 1'b0;
            if (ss_fall) begin
               frame_start    = 1'b1;
               shift_nxt      = {{LEAD_ZEROS{1'b0}}, hold};
               bit_cnt_nxt    = '0;
               miso_nxt       = shift_nxt[FRAME_W-1];
               miso_oe_nxt    = 1'b1;
               sample_ack_nxt = 1'b1;
            end
         end
         SHIFT: begin
            miso_oe_nxt = 1'b1;
            if (ss_rise) begin
               conv_abort_nxt = 1'b1;
               miso_nxt       = 1'b0;
               miso_oe_nxt    = 1'b0;
            end else if (sck_fall) begin
               bit_cnt_nxt = bit_cnt + CNT_W'(1);
               if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                  miso_nxt      = 1'b0;
                  conv_done_nxt = 1'b1;
                  frame_cnt_nxt = frame_cnt + 16'd1;
               end else begin
                  miso_nxt  = shift[FRAME_W-2];
                  shift_nxt = {shift[FRAME_W-2:0], 1'b0};
               end
            end
         end
         DONE: begin
            miso_nxt    = 1'b0;
            miso_oe_nxt = ~ss_rise;
         end
         default: begin
            miso_nxt    = 1'b0;
            miso_oe_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miso       <= 1'b0;
         miso_oe    <= 1'b0;
         shift      <= '0;
         bit_cnt    <= '0;
         sample_ack <= 1'b0;
         conv_done  <= 1'b0;
         conv_abort <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         miso       <= miso_nxt;
         miso_oe    <= miso_oe_nxt;
         shift      <= shift_nxt;
         bit_cnt    <= bit_cnt_nxt;
         sample_ack <= sample_ack_nxt;
         conv_done  <= conv_done_nxt;
         conv_abort <= conv_abort_nxt;
         frame_cnt  <= frame_cnt_nxt;
      end
   end

`ifdef AD7476A_EMU_RAMP_EN
   logic unused_inputs;
   assign unused_inputs = ^{sample_data, sample_valid};

   // The ramp advances after its value has been copied into the shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           hold <= '0;
      else if (frame_start) hold <= hold + DATA_W'(1);
   end
`else
   logic unused_start;
   assign unused_start = frame_start;

   // A load coinciding with a frame start lands after the shift register took the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            hold <= '0;
      else if (sample_valid) hold <= sample_data;
   end
`endif

endmodule

// File: tb/tb_ad7476a_adc_emu.sv
// Self-checking bench for ad7476a_adc_emu: table-driven frames, scoreboarded miso bits,
// plus hand-built abort, reset and load/frame-start collision sequences.
module tb_ad7476a_adc_emu;

   localparam int DATA_W  = 12;
   localparam int FRAME_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ss = 1'b1;
   logic              sck = 1'b1;
   logic [DATA_W-1:0] sample_data = '0;
   logic              sample_valid = 1'b0;
   logic              miso, miso_oe, sample_ack, conv_done, conv_abort;
   logic [15:0]       frame_cnt;

   ad7476a_adc_emu dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ss           (ss),
      .sck          (sck),
      .miso         (miso),
      .miso_oe      (miso_oe),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ack   (sample_ack),
      .conv_done    (conv_done),
      .conv_abort   (conv_abort),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int n_done = 0, n_abort = 0, n_ack = 0;
   int half_clk = 5;
   logic [DATA_W-1:0] hold_m = '0;
   logic [15:0]       fcnt_m = '0;
   bit                exp_q[$];

   typedef struct {
      logic [DATA_W-1:0] value;
      int                falls;
      int                exp_done;
      int                exp_abort;
   } vec_t;

   always @(negedge clk) begin
      if (conv_done)  n_done++;
      if (conv_abort) n_abort++;
      if (sample_ack) n_ack++;
   end

   initial begin
      #50ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [DATA_W-1:0] v);
      @(negedge clk);
      sample_data  = v;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
`ifndef AD7476A_EMU_RAMP_EN
      hold_m = v;
`endif
   endtask

   // One ss-low window with a given number of sck falls; miso is read just before each fall.
   task automatic run_frame(input int falls, input int exp_done, input int exp_abort,
                            input bit coincide, input logic [DATA_W-1:0] new_val);
      int d0, a0, k0;
      logic [FRAME_W-1:0] word;
      bit b;
      d0 = n_done; a0 = n_abort; k0 = n_ack;
      @(negedge clk);
      ss = 1'b0;
      word = {4'b0000, hold_m};
      for (int i = 0; i < falls; i++)
         exp_q.push_back(i < FRAME_W ? word[FRAME_W-1-i] : 1'b0);
`ifdef AD7476A_EMU_RAMP_EN
      hold_m = hold_m + 1'b1;
`endif
      if (coincide) begin
         wait_n(3);
         sample_data  = new_val;
         sample_valid = 1'b1;
         wait_n(1);
         sample_valid = 1'b0;
         check("ack_at_collision", sample_ack, 1);
         hold_m = new_val;
         wait_n(half_clk - 4);
      end else begin
         wait_n(half_clk);
      end
      check("oe_in_frame", miso_oe, 1);
      for (int k = 0; k < falls; k++) begin
         b = exp_q.pop_front();
         check($sformatf("bit%0d", k + 1), miso, b);
         sck = 1'b0;
         wait_n(half_clk);
         sck = 1'b1;
         wait_n(half_clk);
      end
      ss = 1'b1;
      wait_n(4);
      check("miso_after_ss", miso, 0);
      check("oe_after_ss", miso_oe, 0);
      wait_n(2);
      if (exp_done != 0) fcnt_m = fcnt_m + 16'd1;
      check("frame_cnt", frame_cnt, fcnt_m);
      check("done_pulses", n_done - d0, exp_done);
      check("abort_pulses", n_abort - a0, exp_abort);
      check("ack_pulses", n_ack - k0, 1);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{12'hA5C, 16, 1, 0};
      vecs[1] = '{12'h555,  7, 0, 1};
      vecs[2] = '{12'h3E7, 16, 1, 0};
      vecs[3] = '{12'h9C3, 20, 1, 0};
      vecs[4] = '{12'hFFF, 16, 1, 0};
      vecs[5] = '{12'h000, 16, 1, 0};
      vecs[6] = '{12'h800, 16, 1, 0};

      wait_n(3);
      check("rst_miso", miso, 0);
      check("rst_oe", miso_oe, 0);
      check("rst_ack", sample_ack, 0);
      check("rst_done", conv_done, 0);
      check("rst_abort", conv_abort, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_n(3);

`ifdef AD7476A_EMU_RAMP_EN
      half_clk = 4;
      for (int n = 0; n < 4097; n++)
         run_frame(FRAME_W, 1, 0, 1'b0, '0);
      check("ramp_frame_cnt", frame_cnt, 4097);
`else
      for (int v = 0; v < 7; v++) begin
         load(vecs[v].value);
         run_frame(vecs[v].falls, vecs[v].exp_done, vecs[v].exp_abort, 1'b0, '0);
      end

      // Load collides with frame start: old value is sent, new value is kept for next frame.
      load(12'h001);
      run_frame(FRAME_W, 1, 0, 1'b1, 12'h7FF);
      run_frame(FRAME_W, 1, 0, 1'b0, '0);

      // Reset in the middle of bit 9.
      load(12'h3C3);
      @(negedge clk);
      ss = 1'b0;
      wait_n(half_clk);
      for (int k = 0; k < 8; k++) begin
         sck = 1'b0;
         wait_n(half_clk);
         sck = 1'b1;
         wait_n(half_clk);
      end
      check("mid_frame_oe", miso_oe, 1);
      sck = 1'b0;
      wait_n(2);
      rst_n = 1'b0;
      #1;
      check("rstmid_miso", miso, 0);
      check("rstmid_oe", miso_oe, 0);
      check("rstmid_ack", sample_ack, 0);
      check("rstmid_done", conv_done, 0);
      check("rstmid_abort", conv_abort, 0);
      check("rstmid_frame_cnt", frame_cnt, 0);
      fcnt_m = '0;
      hold_m = '0;
      ss  = 1'b1;
      sck = 1'b1;
      wait_n(3);
      rst_n = 1'b1;
      wait_n(3);
      load(12'h123);
      run_frame(FRAME_W, 1, 0, 1'b0, '0);
`endif

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ad7476a_adc_emu.md
Name: ad7476a_adc_emu

Overview:
- Synthesizable responder-side model of the AD7476A serial ADC interface.
- Drives miso in response to ss/sck from the existing AD7476A SPI master, so the master can be exercised on hardware or in simulation without a physical ADC.
- Oversamples ss/sck on the system clock and emits 16-bit frames: LEAD_ZEROS zeros, then a DATA_W-bit sample, MSB first.
- The sample comes from an upstream holding register, or from an internal ramp when compiled in.

Parameters:
- DATA_W, 12, sample width in bits.
- LEAD_ZEROS, 4, leading zero bits per frame; frame length FRAME_W = LEAD_ZEROS + DATA_W = 16.
- SYNC_STAGES, 2, synchronizer depth for ss and sck (minimum 2).

Ports:
- clk  in  1  system clock; must run at least 8x the sck frequency.
- rst_n  in  1  asynchronous active-low reset.
- ss  in  1  chip select from master, active low, asynchronous to clk.
- sck  in  1  serial clock from master, asynchronous to clk.
- miso  out  1  serial data to master.
- miso_oe  out  1  1 while ss is low (synchronized); models the SDATA tri-state enable.
- sample_data  in  DATA_W  next conversion value.
- sample_valid  in  1  load sample_data into the holding register this cycle.
- sample_ack  out  1  1-cycle pulse when the holding register is consumed by a frame start.
- conv_done  out  1  1-cycle pulse after the FRAME_W-th sck falling edge.
- conv_abort  out  1  1-cycle pulse when ss rises before the frame completes.
- frame_cnt  out  16  count of completed frames; wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release):
  - miso=0, miso_oe=0, sample_ack=0, conv_done=0, conv_abort=0, frame_cnt=0.
  - Holding register=0, shift register=0, bit counter=0, state=IDLE.
  - Synchronizers preset to ss=1, sck=1.
- Synchronization: ss and sck each pass through SYNC_STAGES flops plus one edge-detect flop. Edge events are visible SYNC_STAGES+1 clk after the pin change. miso changes 1 clk after the detected event, i.e. 4 clk total with defaults.
- Holding register: loads sample_data whenever sample_valid=1. If sample_valid coincides with a frame start, the frame uses the old holding value and the new value is loaded.
- States:
  - IDLE: miso=0, miso_oe=0. On ss falling edge:
    - shift register <= {LEAD_ZEROS zeros, holding};
    - sample_ack pulses; bit counter=0;
    - miso <= shift bit FRAME_W-1 (0); miso_oe=1;
    - -> SHIFT.
  - SHIFT: on each sck falling edge, bit counter+1 and miso <= next lower bit.
    - After 15 falling edges miso holds the LSB.
    - On the 16th falling edge: miso <= 0, conv_done pulses, frame_cnt+1, -> DONE.
  - DONE: miso=0, miso_oe=1. Further sck edges are ignored. On ss rising edge -> IDLE with no pulse.
- Abort: ss rising edge while in SHIFT -> conv_abort pulses, miso=0, miso_oe=0, -> IDLE. frame_cnt is unchanged.
- sck falling and ss rising detected in the same cycle: ss wins. This is an abort if the frame is not complete; the bit is not counted.
- sck edges while ss is high are ignored.
- sck rising edges never change miso.
- Reset asserted mid-frame: immediate return to reset values; no pulses are generated.

Optional Feature:
- Macro AD7476A_EMU_RAMP_EN.
- Defined: sample_data and sample_valid are ignored. The holding register is an internal DATA_W-bit ramp that increments by 1 on each frame start, after being copied into the shift register. It wraps 0xFFF->0x000. Reset value is 0, so frame N carries value N-1 (first frame 0x000). sample_ack still pulses on each frame start.
- Undefined: external holding register as described under Behaviour.

Test Plan:
- Load sample 0xA5C (sample_valid 1 cycle); ss low, 16 sck cycles at clk/10, sampling miso on sck rising edges -> bits 0000_1010_0101_1100; conv_done once; frame_cnt=1; sample_ack once at ss fall.
- ss low, 7 sck falls, ss high -> conv_abort pulse; frame_cnt unchanged; miso=0 and miso_oe=0 within 4 clk of the ss rise; next full frame is correct.
- 20 sck falls within one ss-low window -> bits 17-20 read 0; exactly one conv_done; ss rise produces no conv_abort.
- rst_n low during bit 9 of a frame -> all outputs 0 immediately; after release, a new frame of 0x123 reads back correctly.
- sample_valid=1 with 0x7FF in the same cycle the ss fall is detected, holding previously 0x001 -> frame carries 0x001; next frame carries 0x7FF.
- With AD7476A_EMU_RAMP_EN: 4097 consecutive frames -> values 0x000,0x001,...,0xFFF,0x000; frame_cnt=4097.
